// File: rtl/player_motion_pkg.sv
// Shared types and helpers for the per-fighter motion engine.
// Holds the state encoding, the default velocity width and saturating velocity add.
package player_motion_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_HIT    = 2'd2,
    ST_LAND   = 2'd3
  } motion_state_t;

  localparam int PM_VEL_WIDTH = 6;

  // a + b, capped at lim above and at the most negative code below.
  function automatic logic signed [PM_VEL_WIDTH-1:0] sat_add(
    input logic signed [PM_VEL_WIDTH-1:0] a,
    input logic signed [PM_VEL_WIDTH-1:0] b,
    input logic signed [PM_VEL_WIDTH-1:0] lim
  );
    logic signed [PM_VEL_WIDTH:0] s;
    s = $signed({a[PM_VEL_WIDTH-1], a}) + $signed({b[PM_VEL_WIDTH-1], b});
    if (s > $signed({lim[PM_VEL_WIDTH-1], lim}))
      sat_add = lim;
    else if (s[PM_VEL_WIDTH] != s[PM_VEL_WIDTH-1])
      sat_add = {1'b1, {(PM_VEL_WIDTH-1){1'b0}}};
    else
      sat_add = s[PM_VEL_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/player_axis_step.sv
// One axis of motion: next = pos + vel, pinned into [lo, hi].
// hit flags that the raw sum fell outside the range and was pinned.
module player_axis_step #(
  parameter int POS_WIDTH = 10,
  parameter int VEL_WIDTH = 6
) (
  input  logic                        [POS_WIDTH-1:0] pos,
  input  logic signed                 [VEL_WIDTH-1:0] vel,
  input  logic                        [POS_WIDTH-1:0] lo,
  input  logic                        [POS_WIDTH-1:0] hi,
  output logic                        [POS_WIDTH-1:0] next_pos,
  output logic                                        hit
);

  localparam int SW = POS_WIDTH + 2;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] lo_s;
  logic signed [SW-1:0] hi_s;

  // Two guard bits let a negative velocity take the sum below zero without wrapping.
  assign lo_s = $signed({2'b00, lo});
  assign hi_s = $signed({2'b00, hi});
  assign sum  = $signed({2'b00, pos}) + $signed({{(SW-VEL_WIDTH){vel[VEL_WIDTH-1]}}, vel});

  always_comb begin
    next_pos = sum[POS_WIDTH-1:0];
    hit      = 1'b0;
    if (sum < lo_s) begin
      next_pos = lo;
      hit      = 1'b1;
    end else if (sum > hi_s) begin
      next_pos = hi;
      hit      = 1'b1;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Per-fighter motion engine: walking, gravity-integrated jumps, knockback and landing recovery.
// Optional feature: define PLAYER_MOTION_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module player_motion
  import player_motion_pkg::*;
#(
  parameter int POS_WIDTH   = 10,
  parameter int VEL_WIDTH   = PM_VEL_WIDTH,
  parameter int GROUND_Y    = 430,
  parameter int CEIL_Y      = 40,
  parameter int START_X     = 40,
  parameter int MIN_X       = 40,
  parameter int MAX_X       = 600,
  parameter int WALK_SPEED  = 4,
  parameter int AIR_SPEED   = 4,
  parameter int JUMP_VEL    = 10,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 12,
  parameter int LAND_FRAMES = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        SCEN,
  input  logic                        move_enable,
  input  logic                        move_left,
  input  logic                        move_right,
  input  logic                        jump,
  input  logic                        kb_valid,
  input  logic signed [VEL_WIDTH-1:0] kb_vel_x,
  input  logic signed [VEL_WIDTH-1:0] kb_vel_y,
  output logic                        kb_ack,
  input  logic        [POS_WIDTH-1:0] opponent_x,
  output logic        [POS_WIDTH-1:0] pos_x,
  output logic        [POS_WIDTH-1:0] pos_y,
  output logic signed [VEL_WIDTH-1:0] vel_x,
  output logic signed [VEL_WIDTH-1:0] vel_y,
  output logic                        facing_right,
  output logic                  [1:0] state,
  output logic                        move_active,
  output logic                        jump_active,
  output logic                        landed
);

  localparam logic [POS_WIDTH-1:0] GROUND_P = POS_WIDTH'(GROUND_Y);
  localparam logic [POS_WIDTH-1:0] CEIL_P   = POS_WIDTH'(CEIL_Y);
  localparam logic [POS_WIDTH-1:0] START_P  = POS_WIDTH'(START_X);
  localparam logic [POS_WIDTH-1:0] MIN_P    = POS_WIDTH'(MIN_X);
  localparam logic [POS_WIDTH-1:0] MAX_P    = POS_WIDTH'(MAX_X);

  localparam logic signed [VEL_WIDTH-1:0] WALK_V = VEL_WIDTH'(WALK_SPEED);
  localparam logic signed [VEL_WIDTH-1:0] AIR_V  = VEL_WIDTH'(AIR_SPEED);
  localparam logic signed [VEL_WIDTH-1:0] JUMP_V = VEL_WIDTH'(-JUMP_VEL);
  localparam logic signed [VEL_WIDTH-1:0] GRAV_V = VEL_WIDTH'(GRAVITY);
  localparam logic signed [VEL_WIDTH-1:0] FALL_V = VEL_WIDTH'(MAX_FALL);

  localparam int CNT_W = (LAND_FRAMES > 1) ? $clog2(LAND_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'((LAND_FRAMES > 0) ? LAND_FRAMES - 1 : 0);

  motion_state_t               state_q, state_n;
  logic        [CNT_W-1:0]     cnt_q, cnt_n;
  logic        [POS_WIDTH-1:0] pos_x_q, pos_x_n, pos_y_q, pos_y_n;
  logic signed [VEL_WIDTH-1:0] vel_x_q, vel_x_n, vel_y_q, vel_y_n;
  logic                        facing_q, facing_n;
  logic                        landed_q, landed_n;
  logic                        jump_q, jump_n;

  logic                        tick, jump_edge, dir_l, dir_r, airborne, touchdown, dj_fire;
  logic signed [VEL_WIDTH-1:0] walk_v, air_v, step_vx;
  logic        [POS_WIDTH-1:0] x_next, y_next;
  logic                        x_hit, y_hit;

  assign tick      = SCEN & move_enable;
  assign jump_edge = jump & ~jump_q;
  assign dir_l     = move_left & ~move_right;
  assign dir_r     = move_right & ~move_left;
  assign walk_v    = dir_r ? WALK_V : (dir_l ? -WALK_V : '0);
  assign air_v     = dir_r ? AIR_V : (dir_l ? -AIR_V : '0);
  assign airborne  = (state_q == ST_AIR) || (state_q == ST_HIT);

  // On the ground the X step uses this frame's walk speed; in flight it uses the locked velocity.
  assign step_vx   = (state_q == ST_GROUND) ? walk_v : vel_x_q;

  player_axis_step #(.POS_WIDTH(POS_WIDTH), .VEL_WIDTH(VEL_WIDTH)) u_axis_x (
    .pos      (pos_x_q),
    .vel      (step_vx),
    .lo       (MIN_P),
    .hi       (MAX_P),
    .next_pos (x_next),
    .hit      (x_hit)
  );

  player_axis_step #(.POS_WIDTH(POS_WIDTH), .VEL_WIDTH(VEL_WIDTH)) u_axis_y (
    .pos      (pos_y_q),
    .vel      (vel_y_q),
    .lo       (CEIL_P),
    .hi       (GROUND_P),
    .next_pos (y_next),
    .hit      (y_hit)
  );

  // The Y step is pinned at the floor, so reaching it exactly is the touchdown test.
  assign touchdown = tick & airborne & ~kb_valid & ~dj_fire & (y_next == GROUND_P);

`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
  logic dj_avail_q;

  assign dj_fire = tick & ~kb_valid & (state_q == ST_AIR) & jump_edge & dj_avail_q;

  // One mid-air jump per flight, re-armed whenever the fighter lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      dj_avail_q <= 1'b1;
    else if (touchdown)
      dj_avail_q <= 1'b1;
    else if (dj_fire)
      dj_avail_q <= 1'b0;
  end
`else
  assign dj_fire = 1'b0;
`endif

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    pos_x_n  = pos_x_q;
    pos_y_n  = pos_y_q;
    vel_x_n  = vel_x_q;
    vel_y_n  = vel_y_q;
    facing_n = facing_q;
    jump_n   = jump_q;
    landed_n = 1'b0;

    if (tick) begin
      jump_n = jump;

      if (((state_q == ST_GROUND) || (state_q == ST_LAND)) && (pos_x_q != opponent_x))
        facing_n = (pos_x_q < opponent_x);

      if (kb_valid) begin
        vel_x_n = kb_vel_x;
        vel_y_n = kb_vel_y;
        state_n = ST_HIT;
      end else begin
        case (state_q)
          ST_GROUND: begin
            if (jump_edge) begin
              vel_y_n = JUMP_V;
              vel_x_n = air_v;
              state_n = ST_AIR;
            end else begin
              pos_x_n = x_next;
              vel_x_n = x_hit ? '0 : walk_v;
            end
          end

          ST_AIR, ST_HIT: begin
            if (dj_fire) begin
              vel_y_n = JUMP_V;
              vel_x_n = air_v;
            end else begin
              pos_x_n = x_next;
              pos_y_n = y_next;
              vel_x_n = x_hit ? '0 : vel_x_q;
              vel_y_n = y_hit ? '0 : sat_add(vel_y_q, GRAV_V, FALL_V);
              if (touchdown) begin
                pos_y_n  = GROUND_P;
                vel_x_n  = '0;
                vel_y_n  = '0;
                landed_n = 1'b1;
                if (LAND_FRAMES == 0) begin
                  state_n = ST_GROUND;
                end else begin
                  state_n = ST_LAND;
                  cnt_n   = CNT_START;
                end
              end
            end
          end

          ST_LAND: begin
            if (cnt_q == '0)
              state_n = ST_GROUND;
            else
              cnt_n = cnt_q - 1'b1;
          end

          default: state_n = ST_GROUND;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_GROUND;
      cnt_q    <= '0;
      pos_x_q  <= START_P;
      pos_y_q  <= GROUND_P;
      vel_x_q  <= '0;
      vel_y_q  <= '0;
      facing_q <= 1'b1;
      landed_q <= 1'b0;
      jump_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      pos_x_q  <= pos_x_n;
      pos_y_q  <= pos_y_n;
      vel_x_q  <= vel_x_n;
      vel_y_q  <= vel_y_n;
      facing_q <= facing_n;
      landed_q <= landed_n;
      jump_q   <= jump_n;
    end
  end

  // Acknowledge in the same cycle so the hit logic drops kb_valid before the next tick.
  assign kb_ack       = tick & kb_valid;
  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign vel_x        = vel_x_q;
  assign vel_y        = vel_y_q;
  assign facing_right = facing_q;
  assign state        = state_q;
  assign jump_active  = airborne;
  assign move_active  = (vel_x_q != '0) | airborne;
  assign landed       = landed_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed self-checking bench for player_motion with default parameters.
// Honours PLAYER_MOTION_DOUBLE_JUMP_EN when choosing double-jump expectations.
module tb_player_motion;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              SCEN;
  logic              move_enable;
  logic              move_left;
  logic              move_right;
  logic              jump;
  logic              kb_valid;
  logic signed [5:0] kb_vel_x;
  logic signed [5:0] kb_vel_y;
  logic              kb_ack;
  logic [9:0]        opponent_x;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic signed [5:0] vel_x;
  logic signed [5:0] vel_y;
  logic              facing_right;
  logic [1:0]        state;
  logic              move_active;
  logic              jump_active;
  logic              landed;

  int checks = 0;
  int errors = 0;

  player_motion dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .SCEN         (SCEN),
    .move_enable  (move_enable),
    .move_left    (move_left),
    .move_right   (move_right),
    .jump         (jump),
    .kb_valid     (kb_valid),
    .kb_vel_x     (kb_vel_x),
    .kb_vel_y     (kb_vel_y),
    .kb_ack       (kb_ack),
    .opponent_x   (opponent_x),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .vel_x        (vel_x),
    .vel_y        (vel_y),
    .facing_right (facing_right),
    .state        (state),
    .move_active  (move_active),
    .jump_active  (jump_active),
    .landed       (landed)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; SCEN = 1'b1; move_enable = 1'b1; move_left = 1'b0; move_right = 1'b0;
    jump = 1'b0; kb_valid = 1'b0; kb_vel_x = '0; kb_vel_y = '0; opponent_x = 10'd300;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    step(5);
    checks++; if (pos_x !== 10'd40) begin errors++; $display("[TB] FAIL reset_pos_x got %0d expected 40", pos_x); end
    checks++; if (pos_y !== 10'd430) begin errors++; $display("[TB] FAIL reset_pos_y got %0d expected 430", pos_y); end
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d expected 0", state); end
    checks++; if (facing_right !== 1'b1) begin errors++; $display("[TB] FAIL reset_facing got %0b expected 1", facing_right); end
    checks++; if (landed !== 1'b0) begin errors++; $display("[TB] FAIL reset_landed got %0b expected 0", landed); end
    checks++; if (kb_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_kb_ack got %0b expected 0", kb_ack); end
    checks++; if (move_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_move_active got %0b expected 0", move_active); end
    checks++; if (jump_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_jump_active got %0b expected 0", jump_active); end
    checks++; if (vel_x !== 0 || vel_y !== 0) begin errors++; $display("[TB] FAIL reset_vel got %0d,%0d expected 0,0", vel_x, vel_y); end
  endtask

  task automatic test_jump_arc();
    int exp_y;
    jump = 1'b1;
    step(1);
    jump = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL takeoff_state got %0d expected 1", state); end
    checks++; if (vel_y !== -10) begin errors++; $display("[TB] FAIL takeoff_vel_y got %0d expected -10", vel_y); end
    checks++; if (pos_y !== 10'd430) begin errors++; $display("[TB] FAIL takeoff_pos_y got %0d expected 430", pos_y); end
    for (int t = 1; t <= 21; t++) begin
      step(1);
      case (t)
        1:       exp_y = 420;
        2:       exp_y = 411;
        3:       exp_y = 403;
        10:      exp_y = 375;
        11:      exp_y = 375;
        20:      exp_y = 420;
        21:      exp_y = 430;
        default: exp_y = -1;
      endcase
      if (exp_y >= 0) begin
        checks++;
        if (pos_y !== exp_y[9:0]) begin errors++; $display("[TB] FAIL arc_pos_y tick %0d got %0d expected %0d", t, pos_y, exp_y); end
      end
      if (t == 20) begin
        checks++; if (state !== 2'd1 || landed !== 1'b0) begin errors++; $display("[TB] FAIL arc_before_land state %0d landed %0b expected 1 0", state, landed); end
      end
    end
    checks++; if (landed !== 1'b1) begin errors++; $display("[TB] FAIL touchdown_landed got %0b expected 1", landed); end
    checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL touchdown_state got %0d expected 3", state); end
    checks++; if (vel_y !== 0) begin errors++; $display("[TB] FAIL touchdown_vel_y got %0d expected 0", vel_y); end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++;
      if (state !== ((k < 4) ? 2'd3 : 2'd0)) begin errors++; $display("[TB] FAIL land_state tick %0d got %0d expected %0d", k, state, (k < 4) ? 3 : 0); end
      if (k == 1) begin
        checks++; if (landed !== 1'b0) begin errors++; $display("[TB] FAIL landed_pulse_width got %0b expected 0", landed); end
      end
    end
  endtask

  task automatic test_jump_hold();
    jump = 1'b1;
    step(1);
    checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL hold_launch got %0d expected 1", state); end
    step(28);
    checks++; if (state !== 2'd0 || pos_y !== 10'd430) begin errors++; $display("[TB] FAIL hold_no_relaunch state %0d pos_y %0d expected 0 430", state, pos_y); end
    jump = 1'b0;
    step(1);
    jump = 1'b1;
    step(1);
    checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL hold_new_edge got %0d expected 1", state); end
    jump = 1'b0;
    step(25);
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL hold_second_land got %0d expected 0", state); end
  endtask

  task automatic test_walk_clamp();
    move_left = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (pos_x !== 10'd40 || vel_x !== 0) begin errors++; $display("[TB] FAIL left_clamp tick %0d pos_x %0d vel_x %0d expected 40 0", i, pos_x, vel_x); end
    end
    move_left = 1'b0; move_right = 1'b1;
    step(1);
    checks++; if (pos_x !== 10'd44 || vel_x !== 4 || move_active !== 1'b1) begin errors++; $display("[TB] FAIL walk_right pos_x %0d vel_x %0d active %0b expected 44 4 1", pos_x, vel_x, move_active); end
    step(139);
    checks++; if (pos_x !== 10'd600 || vel_x !== 4) begin errors++; $display("[TB] FAIL walk_to_max pos_x %0d vel_x %0d expected 600 4", pos_x, vel_x); end
    step(1);
    checks++; if (pos_x !== 10'd600 || vel_x !== 0) begin errors++; $display("[TB] FAIL right_clamp pos_x %0d vel_x %0d expected 600 0", pos_x, vel_x); end
    checks++; if (facing_right !== 1'b0) begin errors++; $display("[TB] FAIL facing_left got %0b expected 0", facing_right); end
    move_right = 1'b0; move_left = 1'b1;
    step(1);
    checks++; if (pos_x !== 10'd596) begin errors++; $display("[TB] FAIL walk_left got %0d expected 596", pos_x); end
    move_left = 1'b0; kb_valid = 1'b1; kb_vel_x = 6'sd2; kb_vel_y = 6'sd0;
    #1;
    checks++; if (kb_ack !== 1'b1) begin errors++; $display("[TB] FAIL nudge_ack got %0b expected 1", kb_ack); end
    step(1);
    kb_valid = 1'b0;
    step(1);
    checks++; if (pos_x !== 10'd598 || state !== 2'd3 || landed !== 1'b1) begin errors++; $display("[TB] FAIL nudge pos_x %0d state %0d landed %0b expected 598 3 1", pos_x, state, landed); end
    step(4);
    move_right = 1'b1;
    step(1);
    checks++; if (pos_x !== 10'd600 || vel_x !== 0) begin errors++; $display("[TB] FAIL edge_598 pos_x %0d vel_x %0d expected 600 0", pos_x, vel_x); end
    move_right = 1'b0; opponent_x = 10'd600;
    step(1);
    checks++; if (facing_right !== 1'b0) begin errors++; $display("[TB] FAIL facing_equal got %0b expected 0", facing_right); end
    opponent_x = 10'd610;
    step(1);
    checks++; if (facing_right !== 1'b1) begin errors++; $display("[TB] FAIL facing_right got %0b expected 1", facing_right); end
    opponent_x = 10'd300;
  endtask

  task automatic test_knockback();
    int exp_y [9] = '{426, 423, 421, 420, 420, 421, 423, 426, 430};
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    move_right = 1'b1;
    step(20);
    checks++; if (pos_x !== 10'd120) begin errors++; $display("[TB] FAIL kb_walk got %0d expected 120", pos_x); end
    move_enable = 1'b0; kb_valid = 1'b1; kb_vel_x = -6'sd6; kb_vel_y = -6'sd4;
    #1;
    checks++; if (kb_ack !== 1'b0) begin errors++; $display("[TB] FAIL kb_frozen_ack got %0b expected 0", kb_ack); end
    step(3);
    checks++; if (pos_x !== 10'd120 || state !== 2'd0 || kb_ack !== 1'b0) begin errors++; $display("[TB] FAIL kb_frozen pos_x %0d state %0d ack %0b expected 120 0 0", pos_x, state, kb_ack); end
    move_enable = 1'b1;
    #1;
    checks++; if (kb_ack !== 1'b1) begin errors++; $display("[TB] FAIL kb_ack got %0b expected 1", kb_ack); end
    step(1);
    kb_valid = 1'b0;
    #1;
    checks++; if (kb_ack !== 1'b0) begin errors++; $display("[TB] FAIL kb_ack_drop got %0b expected 0", kb_ack); end
    checks++; if (state !== 2'd2 || vel_x !== -6 || vel_y !== -4 || pos_x !== 10'd120 || jump_active !== 1'b1) begin
      errors++; $display("[TB] FAIL kb_hit state %0d vel %0d,%0d pos_x %0d jact %0b expected 2 -6,-4 120 1", state, vel_x, vel_y, pos_x, jump_active);
    end
    for (int t = 1; t <= 9; t++) begin
      step(1);
      checks++;
      if (pos_x !== 10'(120 - 6 * t) || pos_y !== exp_y[t-1][9:0]) begin
        errors++; $display("[TB] FAIL kb_flight tick %0d pos %0d,%0d expected %0d,%0d", t, pos_x, pos_y, 120 - 6 * t, exp_y[t-1]);
      end
    end
    checks++; if (state !== 2'd3 || landed !== 1'b1) begin errors++; $display("[TB] FAIL kb_land state %0d landed %0b expected 3 1", state, landed); end
    move_right = 1'b0;
    step(4);
  endtask

  task automatic test_reset_mid_jump();
    jump = 1'b1;
    step(4);
    reset_n = 1'b0;
    #1;
    checks++; if (pos_y !== 10'd430 || state !== 2'd0 || vel_y !== 0) begin errors++; $display("[TB] FAIL async_reset pos_y %0d state %0d vel_y %0d expected 430 0 0", pos_y, state, vel_y); end
    step(1);
    reset_n = 1'b1;
    step(1);
    checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL edge_after_reset got %0d expected 1", state); end
    SCEN = 1'b0;
    step(2);
    checks++; if (pos_y !== 10'd430 || state !== 2'd1) begin errors++; $display("[TB] FAIL scen_hold pos_y %0d state %0d expected 430 1", pos_y, state); end
    SCEN = 1'b1;
    step(1);
    checks++; if (pos_y !== 10'd420) begin errors++; $display("[TB] FAIL scen_resume got %0d expected 420", pos_y); end
    jump = 1'b0;
    step(24);
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL mid_jump_land got %0d expected 0", state); end
  endtask

  task automatic test_double_jump();
    int exp_v5, exp_v7;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
    exp_v5 = -10; exp_v7 = -8;
`else
    exp_v5 = -5;  exp_v7 = -3;
`endif
    jump = 1'b1;
    step(1);
    jump = 1'b0;
    step(4);
    checks++; if (pos_y !== 10'd396) begin errors++; $display("[TB] FAIL dj_pre pos_y got %0d expected 396", pos_y); end
    jump = 1'b1;
    step(1);
    checks++; if (vel_y !== exp_v5) begin errors++; $display("[TB] FAIL dj_second_edge vel_y got %0d expected %0d", vel_y, exp_v5); end
    jump = 1'b0;
    step(1);
    jump = 1'b1;
    step(1);
    checks++; if (vel_y !== exp_v7) begin errors++; $display("[TB] FAIL dj_third_edge vel_y got %0d expected %0d", vel_y, exp_v7); end
    jump = 1'b0;
    for (int i = 0; i < 80 && state !== 2'd3; i++) step(1);
    checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL dj_land_timeout state got %0d expected 3", state); end
    step(4);
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL dj_ground got %0d expected 0", state); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_jump_arc();
    test_jump_hold();
    test_walk_clamp();
    test_knockback();
    test_reset_mid_jump();
    test_double_jump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
